// File: rtl/program_memory_dp.sv
// PLC program memory: registered instruction-fetch port plus a streaming loader
// with origin commands, auto-incrementing writes, running checksum and wrap flag.
module program_memory_dp #(
   parameter int DW             = 16,
   parameter int AW             = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic [AW-1:0] IA,
   input  logic          IRE,
   output logic [DW-1:0] IQ,
   output logic          IVALID,
   input  logic          LD_EN,
   input  logic          LD_VALID,
   input  logic          LD_ORG,
   input  logic [DW-1:0] LD_DATA,
   output logic          LD_READY,
   output logic [AW-1:0] LD_ADDR,
   output logic [DW-1:0] LD_SUM,
   output logic          LD_WRAP,
   output logic          BUSY
);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_RUN,
      S_LOAD
   } state_e;

   localparam logic [AW-1:0] LAST_ADDR = '1;

   state_e        state_q;
   logic [AW-1:0] clr_q;
   logic [DW-1:0] iq_q;
   logic          ivalid_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] sum_q;
   logic          wrap_q;

   logic [DW-1:0] mem_q [0:(1<<AW)-1];

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   logic          data_beat;

   assign data_beat = (state_q == S_LOAD) && LD_VALID && !LD_ORG;

   // Writes are gated by nRST so a reset cycle aborts a clear or load cleanly.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_q;
      mem_wdata = '0;
      if (nRST) begin
         if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
         end else if (data_beat) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = LD_DATA;
         end
      end
   end

   // NOTE: the array has no reset so it maps onto block RAM; zero-fill is done by the CLEAR sweep.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
         clr_q    <= '0;
         iq_q     <= '0;
         ivalid_q <= 1'b0;
         addr_q   <= '0;
         sum_q    <= '0;
         wrap_q   <= 1'b0;
      end else begin
         ivalid_q <= 1'b0;
         unique case (state_q)
            S_CLEAR: begin
               clr_q <= clr_q + 1'b1;
               if (clr_q == LAST_ADDR) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (IRE) begin
                  iq_q     <= mem_q[IA];
                  ivalid_q <= 1'b1;
               end
               if (LD_EN) begin
                  state_q <= S_LOAD;
                  sum_q   <= '0;
                  wrap_q  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (LD_VALID && LD_ORG) begin
                  addr_q <= LD_DATA[AW-1:0];
               end else if (data_beat) begin
                  sum_q  <= sum_q + LD_DATA;
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LAST_ADDR) begin
                     wrap_q <= 1'b1;
                  end
               end
               // A beat in the exit cycle is still taken above.
               if (!LD_EN) begin
                  state_q <= S_RUN;
               end
            end
            default: state_q <= S_RUN;
         endcase
      end
   end

   assign IQ       = iq_q;
   assign IVALID   = ivalid_q;
   assign LD_READY = (state_q == S_LOAD);
   assign LD_ADDR  = addr_q;
   assign LD_SUM   = sum_q;
   assign LD_WRAP  = wrap_q;
   assign BUSY     = (state_q == S_CLEAR);

endmodule

// File: doc/program_memory_dp.md
# program_memory_dp

Parametrised program memory for the PLC CPU with a registered instruction-fetch port and a streaming loader port. It replaces the fixed 16-bit by 4096-word, preloaded store. A loader FSM writes the program at run time: an origin command, auto-incrementing writes, a running checksum and a wrap flag. The memory zero-fills itself after reset. It sits between the CPU fetch stage and the host/debug program loader.

## Interface
- DW, 16, instruction word width (opcode + operand)
- AW, 12, address width; depth = 2^AW words
- CLEAR_ON_RESET, 1, 1: zero-fill whole memory after reset; 0: skip fill, contents undefined until loaded
- CLK  in  1  clock; all logic on rising edge
- nRST  in  1  reset, synchronous, active-low
- IA  in  AW  fetch address
- IRE  in  1  fetch request
- IQ  out  DW  fetched word, registered
- IVALID  out  1  IQ holds MEM[IA] sampled on previous edge
- LD_EN  in  1  loader mode request (CPU halted while high)
- LD_VALID  in  1  loader beat valid
- LD_ORG  in  1  beat is origin command, not data
- LD_DATA  in  DW  beat payload
- LD_READY  out  1  loader beat accepted this cycle when LD_VALID=1
- LD_ADDR  out  AW  current write pointer
- LD_SUM  out  DW  sum mod 2^DW of data words written since entering LOAD
- LD_WRAP  out  1  sticky: pointer wrapped past 2^AW-1 during this LOAD session
- BUSY  out  1  clear sequence in progress

## Operation
- States: CLEAR, RUN, LOAD. On nRST=0 the next state is CLEAR when CLEAR_ON_RESET=1, else RUN.
- CLEAR: writes 0 to address c, with c running 0..2^AW-1, one per cycle. After writing 2^AW-1 it goes to RUN. IRE, LD_EN and LD_VALID are ignored. BUSY=1, LD_READY=0, IVALID=0.
- RUN: IRE=1 captures MEM[IA] into IQ and sets IVALID=1. IRE=0 holds IQ and sets IVALID=0. LD_EN=1 goes to LOAD on the next edge.
- LOAD entry: LD_SUM←0, LD_WRAP←0. LD_ADDR is not cleared and keeps the last pointer.
- LOAD: LD_READY=1 and IVALID=0, with IRE ignored.
  - LD_VALID=1 and LD_ORG=1: LD_ADDR←LD_DATA[AW-1:0]. No write, LD_SUM unchanged.
  - LD_VALID=1 and LD_ORG=0: MEM[LD_ADDR]←LD_DATA, LD_SUM←LD_SUM+LD_DATA (carry dropped), LD_ADDR←LD_ADDR+1 mod 2^AW.
  - A data write at LD_ADDR=2^AW-1 sets LD_WRAP=1 and the pointer becomes 0.
- LD_EN=0 in LOAD goes to RUN on the next edge. A beat presented in that same cycle is still accepted.
- LD_EN held high through CLEAR: LOAD is entered on the edge after CLEAR completes, passing through one RUN cycle.
- Reset mid-CLEAR or mid-LOAD: abort immediately.
  - All state registers are restored to reset values.
  - CLEAR restarts from address 0 if enabled.
  - Memory words already written are not restored.
- The memory array itself is not reset except through CLEAR. There is no fetch/write collision, because fetch is disabled in LOAD.

## Timing
- Reset values of all outputs:
  - IQ=0, IVALID=0, LD_READY=0, LD_ADDR=0, LD_SUM=0, LD_WRAP=0.
  - BUSY=CLEAR_ON_RESET.
- CLEAR length:
  - The first edge with nRST=1 writes address 0, and edge 2^AW writes the last address.
  - BUSY=0 and the state is RUN after edge 2^AW.
  - The first fetch is accepted at edge 2^AW+1.
- Fetch latency is 1 cycle: IRE/IA sampled at edge k gives IQ/IVALID valid after edge k.
  - Back-to-back fetches are supported at one word per cycle.
- LD_READY is combinational from state only, never from LD_VALID.
  - Throughput is one beat per cycle.
  - A write is visible to a fetch one cycle after returning to RUN.
- Mode changes take effect one cycle after LD_EN changes.
  - First LOAD cycle: LD_READY=1.
  - First RUN cycle after LOAD: a fetch may be issued.

## Test plan
- Bench AW=4, DW=16. Reset, then fetch every address → BUSY high for exactly 16 cycles after nRST rises, then every IQ=0x0000 with IVALID one cycle after IRE.
- LOAD: ORG 0x3, then data 0x1111, 0x2222, 0x0FFF, exit, fetch 3..5 → IQ=0x1111, 0x2222, 0x0FFF; LD_SUM=0x4332; LD_ADDR=0x6; LD_WRAP=0.
- LOAD: ORG 0xE, then data 0xFFFF, 0x0002, 0x0003 → addresses 0xE, 0xF, 0x0 written; LD_WRAP=1 after the 0x0002 beat; LD_SUM=0x0004 (carry dropped); LD_ADDR=0x1.
- Second LOAD session with no ORG → LD_SUM and LD_WRAP restart at 0; the first write goes to the previous LD_ADDR.
- LD_EN drops in the same cycle as a data beat → beat written, RUN next cycle; IRE in a LOAD cycle yields IVALID=0.
- nRST pulsed low at CLEAR address 7 (CLEAR_ON_RESET=1) → full 16-cycle clear restarts from 0, all outputs at reset values. With CLEAR_ON_RESET=0 → BUSY never asserts and a fetch succeeds on the first edge after reset.
